// File: rtl/sopc_rst_seq_pkg.sv
// Shared definitions for the SoPC reset sequencer:
// state encoding, reset levels, default parameters.
package sopc_rst_seq_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2,
      ST_DONE    = 2'd3
   } seq_state_e;

   localparam logic RST_ENABLE  = 1'b1;
   localparam logic RST_DISABLE = 1'b0;

   localparam int DEF_NUM_CH      = 2;
   localparam int DEF_HOLD_CYCLES = 10;
   localparam int DEF_STAGE_GAP   = 2;
   localparam int DEF_RUN_LIMIT   = 50;
   localparam int DEF_WDT_LIMIT   = 16;

   // Saturating 8-bit increment for the re-reset counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Counter width able to hold `limit` itself without wrapping.
   function automatic int cnt_width(input int limit);
      return (limit > 0) ? $clog2(limit + 1) : 1;
   endfunction

endpackage

// File: rtl/sopc_rst_seq_timer.sv
// Clearable up-counter with a flag raised one count
// before LIMIT, so the owner can act on the LIMIT-th edge.
module rst_seq_timer #(
   parameter int W     = 4,
   parameter int LIMIT = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         hit
);

   localparam logic [W-1:0] LAST =
      W'((LIMIT > 0) ? LIMIT - 1 : 0);
   localparam logic [W-1:0] ONE = W'(1);

   // Count up when enabled; clear has priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + ONE;
      end
   end

   assign hit = (LIMIT > 0) && (cnt == LAST);

endmodule

// File: rtl/sopc_rst_seq.sv
// Staged reset sequencer: hold, release channels one by
// one, run under a watchdog, optional run-limit completion.
module sopc_rst_seq
   import sopc_rst_seq_pkg::*;
#(
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int STAGE_GAP   = DEF_STAGE_GAP,
   parameter int RUN_LIMIT   = DEF_RUN_LIMIT,
   parameter int WDT_LIMIT   = DEF_WDT_LIMIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sw_rst_req,
   input  logic              wdt_kick,
   output logic [NUM_CH-1:0] ch_rst,
   output logic              run_done,
   output logic              wdt_fired,
   output logic [7:0]        rst_count,
   output logic [1:0]        state
);

   localparam int HMAX =
      (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int HW = cnt_width(HMAX);
   localparam int RW = cnt_width(RUN_LIMIT);
   localparam int WW = cnt_width(WDT_LIMIT);

   localparam logic [HW-1:0] STAGE_LAST = HW'(STAGE_GAP - 1);
   localparam logic [NUM_CH-1:0] ALL_RST = {NUM_CH{RST_ENABLE}};

   seq_state_e        state_q, state_d;
   logic [NUM_CH-1:0] ch_q, ch_d, ch_shift;
   logic              done_q, done_d;
   logic              fire_q, fire_d;
   logic [7:0]        cnt_q, cnt_d;

   logic          hold_clr, hold_en, hold_hit;
   logic          run_clr, run_en, run_hit;
   logic          wdt_clr, wdt_en, wdt_hit;
   logic [HW-1:0] hold_cnt;
   logic [RW-1:0] run_cnt;
   logic [WW-1:0] wdt_cnt;
   logic          unused_cnt;

   // One counter serves both the hold time and the stage gaps.
   rst_seq_timer #(.W(HW), .LIMIT(HOLD_CYCLES)) u_hold (
      .clk (clk),
      .rst (rst),
      .clr (hold_clr),
      .en  (hold_en),
      .cnt (hold_cnt),
      .hit (hold_hit)
   );

   rst_seq_timer #(.W(RW), .LIMIT(RUN_LIMIT)) u_run (
      .clk (clk),
      .rst (rst),
      .clr (run_clr),
      .en  (run_en),
      .cnt (run_cnt),
      .hit (run_hit)
   );

   rst_seq_timer #(.W(WW), .LIMIT(WDT_LIMIT)) u_wdt (
      .clk (clk),
      .rst (rst),
      .clr (wdt_clr),
      .en  (wdt_en),
      .cnt (wdt_cnt),
      .hit (wdt_hit)
   );

   assign unused_cnt = ^{run_cnt, wdt_cnt};

   // Shifting left releases the lowest still-held channel.
   assign ch_shift = ch_q << 1;

   // Next state, channel mask, flags and counter controls.
   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      done_d   = done_q;
      fire_d   = 1'b0;
      cnt_d    = cnt_q;
      hold_clr = 1'b0;
      hold_en  = 1'b0;
      run_clr  = 1'b0;
      run_en   = 1'b0;
      wdt_clr  = 1'b0;
      wdt_en   = 1'b0;
      if (sw_rst_req) begin
         state_d  = ST_HOLD;
         ch_d     = ALL_RST;
         done_d   = 1'b0;
         cnt_d    = sat_inc8(cnt_q);
         hold_clr = 1'b1;
         run_clr  = 1'b1;
         wdt_clr  = 1'b1;
      end else begin
         unique case (state_q)
            ST_HOLD: begin
               hold_en = 1'b1;
               if (hold_hit) begin
                  ch_d     = ch_shift;
                  hold_clr = 1'b1;
                  state_d  = (ch_shift == '0) ? ST_RUN
                                              : ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               hold_en = 1'b1;
               if (hold_cnt == STAGE_LAST) begin
                  ch_d     = ch_shift;
                  hold_clr = 1'b1;
                  if (ch_shift == '0) begin
                     state_d = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               run_en  = 1'b1;
               wdt_en  = 1'b1;
               wdt_clr = wdt_kick;
               if (run_hit) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else if (wdt_hit && !wdt_kick) begin
                  fire_d   = 1'b1;
                  state_d  = ST_HOLD;
                  ch_d     = ALL_RST;
                  cnt_d    = sat_inc8(cnt_q);
                  hold_clr = 1'b1;
                  run_clr  = 1'b1;
                  wdt_clr  = 1'b1;
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_HOLD;
            end
         endcase
      end
   end

   // Registered state and outputs, cleared by async reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_HOLD;
         ch_q    <= ALL_RST;
         done_q  <= 1'b0;
         fire_q  <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         done_q  <= done_d;
         fire_q  <= fire_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ch_rst    = ch_q;
   assign run_done  = done_q;
   assign wdt_fired = fire_q;
   assign rst_count = cnt_q;
   assign state     = state_q;

endmodule

// File: tb/tb_sopc_rst_seq.sv
// Randomised bench for the reset sequencer: two instances
// (defaults and 4 channels / gap 3) against a timeline model.
module tb_sopc_rst_seq;

   localparam int HOLD  = 10;
   localparam int RUN_L = 50;
   localparam int WDT_L = 16;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic sw   = 1'b0;
   logic kick = 1'b0;

   logic [1:0] a_ch;
   logic       a_done, a_fired;
   logic [7:0] a_cnt;
   logic [1:0] a_state;

   logic [3:0] b_ch;
   logic       b_done, b_fired;
   logic [7:0] b_cnt;
   logic [1:0] b_state;

   always #5 clk = ~clk;

   sopc_rst_seq dut_a (
      .clk        (clk),
      .rst        (rst),
      .sw_rst_req (sw),
      .wdt_kick   (kick),
      .ch_rst     (a_ch),
      .run_done   (a_done),
      .wdt_fired  (a_fired),
      .rst_count  (a_cnt),
      .state      (a_state)
   );

   sopc_rst_seq #(
      .NUM_CH      (4),
      .HOLD_CYCLES (HOLD),
      .STAGE_GAP   (3),
      .RUN_LIMIT   (RUN_L),
      .WDT_LIMIT   (WDT_L)
   ) dut_b (
      .clk        (clk),
      .rst        (rst),
      .sw_rst_req (sw),
      .wdt_kick   (kick),
      .ch_rst     (b_ch),
      .run_done   (b_done),
      .wdt_fired  (b_fired),
      .rst_count  (b_cnt),
      .state      (b_state)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t",
                    tag, got, exp, $time);
   endtask

   // Model: edges since the sequence (re)started, plus
   // watchdog age, completion flag and re-reset tally.
   int p_n[2]   = '{2, 4};
   int p_gap[2] = '{2, 3};
   int m_t[2];
   int m_wdt[2];
   int m_cnt[2];
   bit m_done[2];
   bit m_fire[2];

   function automatic int t_run(input int i);
      return HOLD + (p_n[i] - 1) * p_gap[i];
   endfunction

   function automatic bit in_run(input int i);
      return !m_done[i] && (m_t[i] >= t_run(i));
   endfunction

   function automatic int exp_state(input int i);
      if (m_done[i]) return 3;
      if (m_t[i] < HOLD) return 0;
      if (m_t[i] < t_run(i)) return 1;
      return 2;
   endfunction

   function automatic logic [31:0] exp_ch(input int i);
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < p_n[i]; k++)
         v[k] = (m_t[i] < HOLD + k * p_gap[i]);
      return v;
   endfunction

   task automatic mdl_reset();
      for (int i = 0; i < 2; i++) begin
         m_t[i] = 0; m_wdt[i] = 0; m_cnt[i] = 0;
         m_done[i] = 0; m_fire[i] = 0;
      end
   endtask

   task automatic mdl_step(input int i, input bit s,
                           input bit k);
      m_fire[i] = 0;
      if (s) begin
         m_t[i] = 0; m_wdt[i] = 0; m_done[i] = 0;
         m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
      end else if (m_done[i]) begin
         m_done[i] = 1;
      end else if (m_t[i] >= t_run(i)) begin
         if (m_t[i] + 1 - t_run(i) == RUN_L) begin
            m_done[i] = 1;
            m_t[i]++;
         end else if (!k && m_wdt[i] + 1 == WDT_L) begin
            m_fire[i] = 1;
            m_t[i] = 0; m_wdt[i] = 0;
            m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
         end else begin
            m_t[i]++;
            m_wdt[i] = k ? 0 : m_wdt[i] + 1;
         end
      end else begin
         m_t[i]++;
      end
   endtask

   task automatic check_all();
      chk("a_ch", a_ch, exp_ch(0));
      chk("a_state", a_state, exp_state(0));
      chk("a_done", a_done, m_done[0]);
      chk("a_fired", a_fired, m_fire[0]);
      chk("a_cnt", a_cnt, m_cnt[0]);
      chk("b_ch", b_ch, exp_ch(1));
      chk("b_state", b_state, exp_state(1));
      chk("b_done", b_done, m_done[1]);
      chk("b_fired", b_fired, m_fire[1]);
      chk("b_cnt", b_cnt, m_cnt[1]);
   endtask

   task automatic step(input bit s, input bit k);
      sw = s; kick = k;
      @(posedge clk);
      if (!rst) begin
         mdl_step(0, s, k);
         mdl_step(1, s, k);
      end
      #1;
      sw = 1'b0; kick = 1'b0;
      check_all();
   endtask

   initial begin
      int run_at, fire_at, ch0_at, ch1_at, done_at, r, prev;
      bit k, any_fire, reached;

      mdl_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // Free run with no kicks: release timing and watchdog.
      run_at = -1; fire_at = -1; ch0_at = -1; ch1_at = -1;
      for (int c = 0; c < 80; c++) begin
         step(1'b0, 1'b0);
         if (!a_ch[0] && ch0_at < 0) ch0_at = c + 1;
         if (!a_ch[1] && ch1_at < 0) ch1_at = c + 1;
         if (a_state == 2'd2 && run_at < 0) run_at = c + 1;
         if (a_fired && fire_at < 0) begin
            fire_at = c + 1;
            chk("wdt_state", a_state, 0);
            chk("wdt_cnt", a_cnt, 1);
         end
      end
      chk("ch0_edge", ch0_at, 10);
      chk("ch1_edge", ch1_at, 12);
      chk("run_edge", run_at, 12);
      chk("wdt_lat", fire_at - run_at, 16);

      // Periodic kicks; last kick lines expiry up with done.
      step(1'b1, 1'b0);
      run_at = -1; done_at = -1; any_fire = 0;
      for (int c = 0; c < 150 && done_at < 0; c++) begin
         r = m_t[0] + 1 - t_run(0);
         k = in_run(0) && (r == 8 || r == 16 || r == 24 ||
                           r == 32 || r == 34);
         step(1'b0, k);
         if (a_fired) any_fire = 1;
         if (a_state == 2'd2 && run_at < 0) run_at = c + 1;
         if (a_done && done_at < 0) done_at = c + 1;
      end
      chk("done_lat", done_at - run_at, 50);
      chk("done_st", a_state, 3);
      chk("no_wdt", any_fire, 0);
      repeat (6) step(1'b0, 1'b1);
      chk("done_hold", a_state, 3);

      // Software request on the cycle the watchdog expires.
      step(1'b1, 1'b0);
      reached = 0;
      for (int c = 0; c < 200 && !reached; c++) begin
         if (in_run(0) && m_wdt[0] == WDT_L - 1) reached = 1;
         else step(1'b0, 1'b0);
      end
      chk("sw_reach", reached, 1);
      prev = m_cnt[0];
      step(1'b1, 1'b0);
      chk("sw_fired", a_fired, 0);
      chk("sw_state", a_state, 0);
      chk("sw_cnt", a_cnt, (prev < 255) ? prev + 1 : 255);

      // Random traffic with sparse and dense kicking.
      for (int c = 0; c < 400; c++) begin
         int div;
         div = ((c / 100) % 2 == 0) ? 3 : 30;
         step($urandom_range(0, 59) == 0,
              $urandom_range(0, div) == 0);
      end

      // Saturation of the re-reset tally.
      repeat (300) step(1'b1, 1'b0);
      chk("sat_a", a_cnt, 255);
      chk("sat_b", b_cnt, 255);

      // Async reset in the middle of channel release.
      reached = 0;
      for (int c = 0; c < 60 && !reached; c++) begin
         if (m_t[1] == HOLD + 4) reached = 1;
         else step(1'b0, 1'b0);
      end
      chk("rel_reach", reached, 1);
      chk("rel_mid", b_ch, 4'b1100);
      rst = 1'b1;
      #1;
      chk("async_b_ch", b_ch, 4'hF);
      chk("async_b_st", b_state, 0);
      chk("async_a_ch", a_ch, 2'b11);
      chk("async_cnt", a_cnt, 0);
      mdl_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;
      repeat (40) step(1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sopc_rst_seq.md
SOPC_RST_SEQ -- requirements
Module: sopc_rst_seq

Interface
REQ-001 Parameter NUM_CH, default 2: number of sequenced reset channels, 1..8.
REQ-002 Parameter HOLD_CYCLES, default 10: cycles all channels stay in reset after rst deasserts, >=1.
REQ-003 Parameter STAGE_GAP, default 2: cycles between successive channel releases, >=1.
REQ-004 Parameter RUN_LIMIT, default 50: RUN cycles before completion; 0 means unlimited.
REQ-005 Parameter WDT_LIMIT, default 16: RUN cycles without a kick before the watchdog fires; 0 disables the watchdog.
REQ-006 Port clk, input, 1: single system clock; all state changes on the rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port sw_rst_req, input, 1: single-cycle software re-reset request.
REQ-009 Port wdt_kick, input, 1: watchdog service pulse.
REQ-010 Port ch_rst, output, NUM_CH: per-channel active-high reset; bit 0 releases first.
REQ-011 Port run_done, output, 1: sticky flag, high once RUN_LIMIT is reached.
REQ-012 Port wdt_fired, output, 1: single-cycle pulse on watchdog expiry.
REQ-013 Port rst_count, output, 8: saturating count of re-resets (watchdog plus software).
REQ-014 Port state, output, 2: current FSM state: HOLD=0, RELEASE=1, RUN=2, DONE=3.

Function
REQ-015 All outputs shall be registered.
REQ-016 In HOLD, all ch_rst bits shall be 1 and the hold counter shall increment every cycle.
REQ-017 ch_rst[0] shall fall exactly HOLD_CYCLES rising edges after entry to HOLD (or after rst deasserts), and the FSM shall enter RELEASE on that same edge.
REQ-018 ch_rst[k] shall fall exactly k*STAGE_GAP edges after ch_rst[0] falls.
REQ-019 Released channels shall stay released.
REQ-020 The FSM shall enter RUN on the edge that releases ch_rst[NUM_CH-1].
REQ-021 When NUM_CH=1, HOLD shall go directly to RUN.
REQ-022 In RUN, the run counter shall increment every cycle.
REQ-023 When the run counter reaches RUN_LIMIT (RUN_LIMIT>0), the FSM shall enter DONE and set run_done to 1 on that edge.
REQ-024 In DONE, channels shall stay released and the FSM shall hold until sw_rst_req.
REQ-025 In RUN, wdt_kick shall clear the watchdog counter.
REQ-026 If the watchdog counter reaches WDT_LIMIT, wdt_fired shall pulse for 1 cycle, all ch_rst bits shall assert, and the FSM shall enter HOLD with all counters cleared.
REQ-027 The watchdog shall count only in RUN.
REQ-028 sw_rst_req in any state shall assert all ch_rst bits, clear run_done and the counters, and enter HOLD on the next edge.
REQ-029 sw_rst_req shall have priority over watchdog expiry and over run-limit completion in the same cycle.
REQ-030 When wdt_kick coincides with watchdog expiry, the kick shall win: no fire, counter cleared.
REQ-031 When run-limit completion coincides with watchdog expiry, completion shall win.
REQ-032 rst_count shall increment once per wdt_fired or accepted sw_rst_req, saturate at 255, and be cleared only by rst.
REQ-033 Counter widths shall be derived from the parameters via clog2, with no wrap before the limit is reached.

Reset
REQ-034 rst high shall asynchronously force state=HOLD, ch_rst all 1, run_done 0, wdt_fired 0, rst_count 0, and all counters 0.
REQ-035 Assertion of rst mid-RELEASE or mid-RUN shall take effect immediately, without waiting for a clock edge.
REQ-036 Sequencing shall restart from the first rising edge with rst low.

Structure
REQ-037 The state encodings, the RST_ENABLE/RST_DISABLE levels and the default parameter values shall live in the shared global definitions include.
REQ-038 One sub-module shall exist: rst_seq_timer, a clearable up-counter with a match flag, parametrised by width and limit.
REQ-039 rst_seq_timer shall be instantiated for the hold/stage counter, the run counter and the watchdog counter.

Verification
REQ-040 Defaults; rst released after 10 cycles -> ch_rst[0] falls at edge 10, ch_rst[1] at edge 12, state=RUN at edge 12.
REQ-041 Defaults, no kicks -> wdt_fired pulses 16 cycles after RUN entry, state=HOLD, rst_count=1, sequence repeats.
REQ-042 Defaults, wdt_kick every 8 cycles -> run_done=1 exactly 50 cycles after RUN entry, state=DONE, no wdt_fired.
REQ-043 sw_rst_req together with watchdog expiry -> wdt_fired stays 0, state=HOLD, rst_count increments by 1.
REQ-044 NUM_CH=4, STAGE_GAP=3 -> channels release at HOLD_CYCLES+0/3/6/9; rst pulsed mid-release -> all ch_rst=1 within the same cycle.
REQ-045 300 forced re-resets -> rst_count=255.
